// File: rtl/pipe_stage_skid_pkg.sv
// Shared types for the reusable pipeline stage register.
// The state encoding is {m_valid, s_valid}, so the valid bits can be read directly from the state.
package pipe_stage_skid_pkg;

   localparam int STAGE_WIDTH_DEFAULT = 64;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'b00,
      ST_ONE   = 2'b10,
      ST_TWO   = 2'b11
   } stage_state_e;

   typedef enum logic [1:0] {
      M_HOLD    = 2'b00,
      M_PAYLOAD = 2'b01,
      M_SKID    = 2'b10
   } m_sel_e;

   function automatic logic [1:0] occupancy(input stage_state_e st);
      logic [1:0] bits;
      bits = st;
      return {1'b0, bits[1]} + {1'b0, bits[0]};
   endfunction

endpackage

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with stall, flush and bubble injection.
// SKID selects a two-entry buffer with registered in_ready, or a single register.
module pipe_stage_skid
   import pipe_stage_skid_pkg::*;
#(
   parameter int               WIDTH     = STAGE_WIDTH_DEFAULT,
   parameter logic [WIDTH-1:0] NOP_VALUE = '0,
   parameter bit               SKID      = 1'b1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_nop,
   input  logic             stall,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       count,
   output logic [1:0]       dbg_state
);

   // Handshake: a transfer happens on a rising edge where valid and ready are both high;
   // the producer holds valid and data stable until that edge, and ready never waits on valid.

   stage_state_e     state_q, state_d;
   m_sel_e           m_sel;
   logic             s_load;
   logic [WIDTH-1:0] m_data_q, s_data_q, payload;
   logic             m_valid, s_valid, in_fire, out_fire;

   assign m_valid   = state_q[1];
   assign s_valid   = state_q[0];
   assign payload   = in_nop ? NOP_VALUE : in_data;
   assign out_valid = m_valid & ~stall;
   // A flushing cycle still shows M downstream, but the stage ignores any pop it sees.
   assign out_fire  = out_valid & out_ready & ~flush;
   assign in_fire   = in_valid & in_ready;
   assign out_data  = m_data_q;
   assign count     = occupancy(state_q);
   assign dbg_state = state_q;

   generate
      if (SKID) begin : g_skid
         assign in_ready = ~s_valid & ~stall & ~flush;

         always_comb begin
            state_d = state_q;
            m_sel   = M_HOLD;
            s_load  = 1'b0;
            if (flush) begin
               state_d = ST_EMPTY;
            end else begin
               case (state_q)
                  ST_EMPTY: begin
                     if (in_fire) begin
                        state_d = ST_ONE;
                        m_sel   = M_PAYLOAD;
                     end
                  end
                  ST_ONE: begin
                     if (in_fire && out_fire) begin
                        m_sel = M_PAYLOAD;
                     end else if (in_fire) begin
                        state_d = ST_TWO;
                        s_load  = 1'b1;
                     end else if (out_fire) begin
                        state_d = ST_EMPTY;
                     end
                  end
                  ST_TWO: begin
                     if (out_fire) begin
                        state_d = ST_ONE;
                        m_sel   = M_SKID;
                     end
                  end
                  default: state_d = ST_EMPTY;
               endcase
            end
         end

         always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
               s_data_q <= NOP_VALUE;
            end else if (s_load) begin
               s_data_q <= payload;
            end
         end
      end else begin : g_single
         assign in_ready = ~stall & ~flush & (~m_valid | out_ready);
         assign s_data_q = NOP_VALUE;

         always_comb begin
            state_d = state_q;
            m_sel   = M_HOLD;
            s_load  = 1'b0;
            if (flush) begin
               state_d = ST_EMPTY;
            end else if (in_fire) begin
               state_d = ST_ONE;
               m_sel   = M_PAYLOAD;
            end else if (out_fire) begin
               state_d = ST_EMPTY;
            end
         end
      end
   endgenerate

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= ST_EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         m_data_q <= NOP_VALUE;
      end else begin
         case (m_sel)
            M_PAYLOAD: m_data_q <= payload;
            M_SKID:    m_data_q <= s_data_q;
            default:   m_data_q <= m_data_q;
         endcase
      end
   end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: a SKID=1 instance for most scenarios, a SKID=0 instance for the single-register mode.
module tb_pipe_stage_skid;

   logic       clock = 1'b0;
   logic       reset;

   logic       in_valid, in_nop, stall, flush, out_ready;
   logic [7:0] in_data;
   logic       in_ready, out_valid;
   logic [7:0] out_data;
   logic [1:0] count, dbg_state;

   logic       in_valid0, in_nop0, stall0, flush0, out_ready0;
   logic [7:0] in_data0;
   logic       in_ready0, out_valid0;
   logic [7:0] out_data0;
   logic [1:0] count0, dbg_state0;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clock = ~clock;

   pipe_stage_skid #(.WIDTH(8), .NOP_VALUE(8'h00), .SKID(1'b1)) dut (
      .clock(clock), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_nop(in_nop),
      .stall(stall), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .count(count), .dbg_state(dbg_state)
   );

   pipe_stage_skid #(.WIDTH(8), .NOP_VALUE(8'h00), .SKID(1'b0)) dut0 (
      .clock(clock), .reset(reset),
      .in_valid(in_valid0), .in_ready(in_ready0), .in_data(in_data0), .in_nop(in_nop0),
      .stall(stall0), .flush(flush0),
      .out_valid(out_valid0), .out_ready(out_ready0), .out_data(out_data0),
      .count(count0), .dbg_state(dbg_state0)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One active edge, then back to the falling edge where inputs change; settle before checks.
   task automatic tick();
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin
      reset = 1'b1;
      in_valid = 0; in_nop = 0; stall = 0; flush = 0; out_ready = 0; in_data = 8'h00;
      in_valid0 = 0; in_nop0 = 0; stall0 = 0; flush0 = 0; out_ready0 = 0; in_data0 = 8'h00;
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;
      settle();
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 8'h00);
      check("rst_count", count, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_in_ready0", in_ready0, 1);

      // Streaming with out_ready held high
      out_ready = 1; in_valid = 1; in_data = 8'h11;
      settle();
      check("str_in_ready0", in_ready, 1);
      tick(); in_data = 8'h22; settle();
      check("str_valid1", out_valid, 1);
      check("str_data1", out_data, 8'h11);
      check("str_in_ready1", in_ready, 1);
      check("str_count1", count, 1);
      tick(); in_data = 8'h33; settle();
      check("str_data2", out_data, 8'h22);
      check("str_in_ready2", in_ready, 1);
      check("str_count2", count, 1);
      tick(); in_valid = 0; settle();
      check("str_data3", out_data, 8'h33);
      check("str_count3", count, 1);
      tick(); settle();
      check("str_empty_valid", out_valid, 0);
      check("str_empty_count", count, 0);

      // Back-pressure fills S, then drains in order
      out_ready = 0; in_valid = 1; in_data = 8'hA1;
      tick(); in_data = 8'hA2; settle();
      check("bp_in_ready1", in_ready, 1);
      check("bp_count1", count, 1);
      tick(); in_data = 8'hA3; settle();
      check("bp_count2", count, 2);
      check("bp_in_ready2", in_ready, 0);
      check("bp_head", out_data, 8'hA1);
      check("bp_state", dbg_state, 2'b11);
      tick(); settle();
      check("bp_hold_count", count, 2);
      check("bp_hold_head", out_data, 8'hA1);
      check("bp_hold_in_ready", in_ready, 0);
      out_ready = 1; settle();
      check("bp_pop1_valid", out_valid, 1);
      check("bp_pop1_data", out_data, 8'hA1);
      tick(); settle();
      check("bp_pop2_data", out_data, 8'hA2);
      check("bp_pop2_in_ready", in_ready, 1);
      check("bp_pop2_count", count, 1);
      tick(); in_valid = 0; settle();
      check("bp_pop3_data", out_data, 8'hA3);
      check("bp_pop3_count", count, 1);
      tick(); settle();
      check("bp_drained", count, 0);

      // Bubble injection stores NOP_VALUE but still occupies the slot
      in_valid = 1; in_data = 8'h55; in_nop = 1;
      tick(); in_valid = 0; in_nop = 0; settle();
      check("nop_valid", out_valid, 1);
      check("nop_data", out_data, 8'h00);
      tick(); settle();
      check("nop_drained", count, 0);

      // Flush with both entries occupied while 0x77 is offered
      out_ready = 0; in_valid = 1; in_data = 8'hB1;
      tick(); in_data = 8'hB2;
      tick(); in_data = 8'h77; flush = 1; out_ready = 1; settle();
      check("fl_pre_count", count, 2);
      check("fl_in_ready", in_ready, 0);
      check("fl_out_valid", out_valid, 1);
      check("fl_out_data", out_data, 8'hB1);
      tick(); flush = 0; in_valid = 0; settle();
      check("fl_count", count, 0);
      check("fl_valid", out_valid, 0);
      check("fl_data_held", out_data, 8'hB1);
      check("fl_in_ready_after", in_ready, 1);
      tick(); settle();
      check("fl_no77_valid", out_valid, 0);

      // Stall for three cycles with 0x66 held in M
      out_ready = 0; in_valid = 1; in_data = 8'h66;
      tick(); stall = 1; out_ready = 1; in_data = 8'h99;
      for (int i = 0; i < 3; i++) begin
         settle();
         check("st_out_valid", out_valid, 0);
         check("st_in_ready", in_ready, 0);
         check("st_count", count, 1);
         tick();
      end
      stall = 0; in_valid = 0; settle();
      check("st_rel_valid", out_valid, 1);
      check("st_rel_data", out_data, 8'h66);
      tick(); settle();
      check("st_drained", count, 0);

      // Asynchronous reset between edges
      out_ready = 0; in_valid = 1; in_data = 8'hC3;
      tick(); in_valid = 0; settle();
      check("ar_pre_valid", out_valid, 1);
      #2 reset = 1'b1;
      #1;
      check("ar_out_valid", out_valid, 0);
      check("ar_count", count, 0);
      check("ar_out_data", out_data, 8'h00);
      @(negedge clock);
      reset = 1'b0;

      // Single-register mode: in_ready follows ~m_valid when out_ready is low
      out_ready0 = 0; in_valid0 = 1; in_data0 = 8'h44; settle();
      check("s0_in_ready_empty", in_ready0, 1);
      check("s0_count_empty", count0, 0);
      tick(); settle();
      check("s0_in_ready_full", in_ready0, 0);
      check("s0_valid", out_valid0, 1);
      check("s0_data", out_data0, 8'h44);
      out_ready0 = 1; in_data0 = 8'h45; settle();
      check("s0_in_ready_pass", in_ready0, 1);
      tick(); in_valid0 = 0; settle();
      check("s0_data2", out_data0, 8'h45);
      check("s0_count2", count0, 1);
      tick(); settle();
      check("s0_drained_count", count0, 0);
      check("s0_drained_valid", out_valid0, 0);
      flush0 = 1; settle();
      check("s0_flush_in_ready", in_ready0, 0);
      flush0 = 0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
